uart_receive: RTL and testbench
===============================

# uart_receive

Serial UART receiver (8N1) for the `receive` block position. It converts an asynchronous serial input into bytes and presents each byte on a one-deep stream output with a strobe/acknowledge handshake. It also flags framing and overrun errors. It sits between the board RX pin and the byte-stream fabric.

## Interface
- `BAUD`, default 9600: serial bit rate in bits/s.
- `FREQ`, default 12e6: `clk` frequency in Hz. Bit period in clocks is `DIV = round(FREQ/BAUD)`, which is 1250 at the defaults.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `rxd`  in  1  serial input, asynchronous, idle high.
- `dat`  out  8  received byte; valid while `stb`=1.
- `stb`  out  1  output byte valid.
- `ack`  in  1  consumer accept; a transfer occurs on a cycle with `stb`=1 and `ack`=1.
- `err`  out  1  sticky error flag.

## Operation
- `rxd` passes through a 2-flop synchronizer before any use. After reset the synchronizer stages are preset to 1 (idle).
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Receive FSM states are IDLE, START, DATA, STOP.
  - IDLE: wait for the synchronized `rxd` to be 0. Then load the bit counter with `DIV/2` and go to START.
  - START: when the counter expires (mid start bit), re-sample `rxd`. If it is 0, go to DATA with counter=`DIV` and bit index 0. If it is 1, treat the event as a glitch and return to IDLE with no error.
  - DATA: at each counter expiry, sample `rxd` into the shift register (LSB first) and reload `DIV`. After the 8th sample, go to STOP.
  - STOP: at counter expiry (mid stop bit), sample `rxd`.
    - If it is 1 and the holding register is empty, load `dat`, set `stb`, and go to IDLE.
    - If it is 1 and `stb` is already set without `ack` on this cycle, this is an overrun. Set `err`, discard the new byte, keep the old byte, and go to IDLE.
    - If it is 0, this is a framing error. Set `err`, discard the byte, and wait for `rxd`=1 before returning to IDLE.
- Output holding register:
  - `stb` clears on the cycle after a transfer (`stb`&`ack`).
  - A stop-bit load on the same cycle as a transfer is legal. The new byte replaces the old one and `stb` stays 1; this is not an overrun.
  - `dat` holds its value while `stb`=0. Its value is then don't-care, but it must not be X after reset.
- The receiver keeps running while the holding register is full. A second byte may be shifted in entirely while the first waits for `ack`.
- `err` stays set until reset.
- Reset (`rst`=0), including mid-frame: FSM to IDLE, counters cleared, `stb`=0, `err`=0, `dat`=0. Any partial frame is dropped.

## Timing
- Reset values: `dat`=0, `stb`=0, `err`=0.
- Sampling points after the start falling edge, with up to 2 cycles of synchronizer delay:
  - start check at about DIV/2;
  - data bit k at about DIV/2 + (k+1)·DIV;
  - stop bit at about 9.5·DIV.
- `stb` rises 1 cycle after the stop-bit sample, about 9.5 bit periods (11875 clocks at the defaults) after the start edge. This is before the end of the stop bit, so back-to-back frames are accepted.
- Handshake: `dat`/`stb` stay stable until accepted. `ack` may be held high in advance; the transfer then completes on the first cycle `stb`=1.
- The byte is available to a consumer from mid stop bit onward. A consumer that reads byte N at any time before byte N+1's stop sample causes no overrun.
- Tolerated baud mismatch: at least ±2% (mid-bit sampling).

## Test plan
- Concurrent: drive 8 random bytes (e.g. 0xA5, 0x00, 0xFF) on `rxd` with `ack` held high -> each `dat` equals the sent byte and `err`=0.
- Sequential: send a byte fully, then assert `ack` later -> `stb` stays high with the correct `dat` until acknowledged, then drops the next cycle.
- Buffered: send 0x3C without reading, then start 0xC3 and assert `ack` 9.5 bit times into it -> first read returns 0x3C, second returns 0xC3, and `err` stays 0 throughout.
- Overrun: send 0x11 then 0x22 with `ack` low -> `err`=1 after the second stop bit, and a later read returns 0x11.
- Framing: send 0x55 with a stop bit of 0 -> no `stb`, `err`=1. After reset, `err`=0 and a valid byte is received normally.
- Glitch and reset: a low pulse on `rxd` shorter than DIV/2 -> no `stb` and no `err`. Assert `rst` mid-frame -> outputs return to 0 and the next full frame receives correctly.

Source files
------------

// File: rtl/uart_receive_if.sv
// Byte-stream side of the UART receiver: one-deep holding register with a
// strobe/acknowledge handshake plus the sticky error flag.
interface uart_receive_if;
  logic [7:0] dat;
  logic       stb;
  logic       ack;
  logic       err;

  modport master (output dat, output stb, output err, input ack);
  modport slave  (input dat, input stb, input err, output ack);
endinterface

// File: rtl/uart_receive.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// one-deep output holding register with overrun/framing error detection.
module uart_receive #(
  parameter int BAUD = 9600,
  parameter int FREQ = 12_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd_i,
  uart_receive_if.master rx_if
);

  // state | meaning
  // IDLE  | line idle, waiting for a falling edge
  // START | timing to mid start bit, glitch rejection
  // DATA  | sampling 8 data bits LSB first
  // STOP  | sampling stop bit; fwait_q set while waiting out a framing error
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int DIV = (FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);

  logic [1:0]    sync_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          fwait_q, fwait_d;
  logic [7:0]    dat_q, dat_d;
  logic          stb_q, stb_d;
  logic          err_q, err_d;
  logic          rxd_s;
  logic          expire;

  assign rxd_s     = sync_q[1];
  assign expire    = (cnt_q == '0);
  assign rx_if.dat = dat_q;
  assign rx_if.stb = stb_q;
  assign rx_if.err = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    fwait_d = fwait_q;
    dat_d   = dat_q;
    stb_d   = stb_q;
    err_d   = err_q;

    if (stb_q && rx_if.ack) stb_d = 1'b0;
    if (!expire) cnt_d = cnt_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          cnt_d   = HALF_LD;
          state_d = START;
        end
      end
      START: begin
        if (expire) begin
          if (!rxd_s) begin
            cnt_d   = FULL_LD;
            idx_d   = 3'd0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_d = {rxd_s, shift_q[7:1]};
          cnt_d   = FULL_LD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (fwait_q) begin
          if (rxd_s) begin
            fwait_d = 1'b0;
            state_d = IDLE;
          end
        end else if (expire) begin
          if (rxd_s) begin
            // A load coinciding with a transfer replaces the old byte legally.
            if (!stb_q || rx_if.ack) begin
              dat_d = shift_q;
              stb_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            fwait_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      fwait_q <= 1'b0;
      dat_q   <= 8'd0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      fwait_q <= fwait_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Scoreboard bench for uart_receive: frames driven on rxd in absolute time,
// expected bytes queued by a frame-level model, transfers checked by a monitor.
module tb_uart_receive;
  localparam int FREQ = 1_000_000;
  localparam int BAUD = 62_500;
  localparam int DIV  = 16;
  localparam int BITT = DIV * 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;

  uart_receive_if rx_if ();

  uart_receive #(.BAUD(BAUD), .FREQ(FREQ)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd_i (rxd),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_err = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Frame-level model: a good frame is delivered unless the previous byte is
  // still unread and the consumer does not read it by the stop-bit sample.
  task automatic expect_frame(input logic [7:0] b, input bit stop_ok, input bit reader_ready);
    if (!stop_ok) exp_err = 1'b1;
    else if (exp_q.size() != 0 && !reader_ready) exp_err = 1'b1;
    else exp_q.push_back(b);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int bit_t);
    rxd = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_t);
    end
    rxd = stop;
    #(bit_t);
    rxd = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic set_ack(input logic v);
    @(posedge clk); #1;
    rx_if.ack = v;
  endtask

  always @(negedge clk) begin
    if (rst && rx_if.stb && rx_if.ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got %h expected none at %0t", rx_if.dat, $time);
      end else begin
        check("dat_xfer", rx_if.dat, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] fixed [3];
    fixed[0] = 8'hA5; fixed[1] = 8'h00; fixed[2] = 8'hFF;
    rx_if.ack = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dat", rx_if.dat, 8'h00);
    check("rst_stb", {7'd0, rx_if.stb}, 8'h00);
    check("rst_err", {7'd0, rx_if.err}, 8'h00);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);

    // Back-to-back frames, ack held high, bit period jittered within +-2%.
    set_ack(1'b1);
    for (int i = 0; i < 8; i++) begin
      b = (i < 3) ? fixed[i] : 8'($urandom_range(0, 255));
      expect_frame(b, 1'b1, 1'b1);
      send_frame(b, 1'b1, BITT + $urandom_range(0, 6) - 3);
    end
    #(2 * BITT);
    @(negedge clk);
    check("conc_err", {7'd0, rx_if.err}, {7'd0, exp_err});
    check("conc_drain", 8'(exp_q.size()), 8'd0);

    // Late acknowledge: byte must wait, then strobe drops the next cycle.
    set_ack(1'b0);
    expect_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, BITT);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("seq_stb_held", {7'd0, rx_if.stb}, 8'h01);
    check("seq_dat_held", rx_if.dat, 8'h5A);
    set_ack(1'b1);
    set_ack(1'b0);
    @(negedge clk);
    check("seq_stb_drop", {7'd0, rx_if.stb}, 8'h00);

    // Second byte arrives while first is held; reader acks at 9.5 bit times.
    expect_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, BITT);
    #(BITT);
    expect_frame(8'hC3, 1'b1, 1'b1);
    fork
      send_frame(8'hC3, 1'b1, BITT);
      begin
        #(BITT * 19 / 2);
        set_ack(1'b1);
      end
    join
    #(2 * BITT);
    set_ack(1'b0);
    @(negedge clk);
    check("buf_err", {7'd0, rx_if.err}, {7'd0, exp_err});
    check("buf_drain", 8'(exp_q.size()), 8'd0);

    // Overrun: second byte dropped, first one kept.
    expect_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1, BITT);
    expect_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, BITT);
    #(2 * BITT);
    @(negedge clk);
    check("ovr_err", {7'd0, rx_if.err}, {7'd0, exp_err});
    check("ovr_stb", {7'd0, rx_if.stb}, 8'h01);
    set_ack(1'b1);
    set_ack(1'b0);
    check("ovr_drain", 8'(exp_q.size()), 8'd0);

    // Framing error, then recovery through reset.
    do_reset();
    @(negedge clk);
    check("fr_pre_err", {7'd0, rx_if.err}, 8'h00);
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, BITT);
    #(3 * BITT);
    @(negedge clk);
    check("fr_stb", {7'd0, rx_if.stb}, 8'h00);
    check("fr_err", {7'd0, rx_if.err}, {7'd0, exp_err});
    do_reset();
    @(negedge clk);
    check("fr_rst_err", {7'd0, rx_if.err}, 8'h00);
    set_ack(1'b1);
    expect_frame(8'h96, 1'b1, 1'b1);
    send_frame(8'h96, 1'b1, BITT);
    #(2 * BITT);
    @(negedge clk);
    check("fr_rx_err", {7'd0, rx_if.err}, {7'd0, exp_err});
    check("fr_drain", 8'(exp_q.size()), 8'd0);

    // Short low glitch must be ignored.
    set_ack(1'b0);
    rxd = 1'b0;
    #(5 * 10);
    rxd = 1'b1;
    #(15 * BITT);
    @(negedge clk);
    check("gl_stb", {7'd0, rx_if.stb}, 8'h00);
    check("gl_err", {7'd0, rx_if.err}, 8'h00);

    // Reset mid-frame with a held byte, then receive normally.
    expect_frame(8'hA7, 1'b1, 1'b0);
    send_frame(8'hA7, 1'b1, BITT);
    #(BITT);
    @(negedge clk);
    check("mr_stb_pre", {7'd0, rx_if.stb}, 8'h01);
    fork
      send_frame(8'hFF, 1'b1, BITT);
      begin
        #(3 * BITT);
        do_reset();
        @(negedge clk);
        check("mr_dat", rx_if.dat, 8'h00);
        check("mr_stb", {7'd0, rx_if.stb}, 8'h00);
        check("mr_err", {7'd0, rx_if.err}, 8'h00);
      end
    join
    #(2 * BITT);
    set_ack(1'b1);
    b = 8'($urandom_range(0, 255));
    expect_frame(b, 1'b1, 1'b1);
    send_frame(b, 1'b1, BITT);
    #(2 * BITT);
    @(negedge clk);
    check("mr_rx_err", {7'd0, rx_if.err}, {7'd0, exp_err});
    check("final_drain", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
